// File: rtl/dwdata_recv.sv
// Depthwise weight-load sequencer: requests one burst at a time from the address
// generator, accepts the returning R beats and writes them into the weight buffer.
module dwdata_recv #(
    parameter  int DW        = 32,
    parameter  int BURST     = 16,
    parameter  int BUF_DEPTH = 256,
    localparam int BA        = $clog2(BUF_DEPTH),
    localparam int CW        = $clog2(BURST)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [7:0]    i_num_bursts,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_weight_load,
    output logic          o_init_addr_en,
    input  logic [DW-1:0] i_rdata,
    input  logic          i_rvalid,
    input  logic          i_rlast,
    input  logic [1:0]    i_rresp,
    output logic          o_rready,
    output logic          o_buf_wr_en,
    output logic [BA-1:0] o_buf_wr_addr,
    output logic [DW-1:0] o_buf_wr_data
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_FIN} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_num_bursts;
    logic [7:0]    r_burst_cnt;
    logic [CW-1:0] r_beat_cnt;
    logic [BA-1:0] r_wr_addr;
    logic          r_err;
    logic          r_buf_wr_en;
    logic [BA-1:0] r_buf_wr_addr;
    logic [DW-1:0] r_buf_wr_data;

    logic w_start_acc;
    logic w_beat_acc;
    logic w_last_beat;
    logic w_last_burst;

    assign w_start_acc  = (r_state == S_IDLE) && i_start;
    assign w_beat_acc   = (r_state == S_DATA) && i_rvalid;
    assign w_last_beat  = (r_beat_cnt == CW'(BURST - 1));
    assign w_last_burst = (8'(r_burst_cnt + 8'd1) == r_num_bursts);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_num_bursts != 8'd0) ? S_REQ : S_FIN;
                end
            end
            S_REQ:  w_state_next = S_DATA;
            S_DATA: begin
                // Burst end is decided by the beat count alone; rlast only feeds err.
                if (w_beat_acc && w_last_beat) begin
                    w_state_next = w_last_burst ? S_FIN : S_REQ;
                end
            end
            S_FIN:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_num_bursts  <= '0;
            r_burst_cnt   <= '0;
            r_beat_cnt    <= '0;
            r_wr_addr     <= '0;
            r_err         <= 1'b0;
            r_buf_wr_en   <= 1'b0;
            r_buf_wr_addr <= '0;
            r_buf_wr_data <= '0;
        end else begin
            r_state     <= w_state_next;
            r_buf_wr_en <= w_beat_acc;
            if (w_beat_acc) begin
                r_buf_wr_data <= i_rdata;
                r_buf_wr_addr <= r_wr_addr;
                r_wr_addr     <= r_wr_addr + BA'(1);
                r_beat_cnt    <= w_last_beat ? '0 : r_beat_cnt + CW'(1);
                if (w_last_beat) begin
                    r_burst_cnt <= r_burst_cnt + 8'd1;
                end
                if ((i_rresp != 2'b00) || (i_rlast != w_last_beat)) begin
                    r_err <= 1'b1;
                end
            end
            if (w_start_acc) begin
                r_num_bursts <= i_num_bursts;
                r_burst_cnt  <= '0;
                r_beat_cnt   <= '0;
                r_wr_addr    <= '0;
                r_err        <= 1'b0;
            end
        end
    end

    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_FIN);
    assign o_err          = r_err;
    assign o_weight_load  = (r_state == S_REQ);
    assign o_init_addr_en = (r_state == S_REQ) && (r_burst_cnt == 8'd0);
    assign o_rready       = (r_state == S_DATA);
    assign o_buf_wr_en    = r_buf_wr_en;
    assign o_buf_wr_addr  = r_buf_wr_addr;
    assign o_buf_wr_data  = r_buf_wr_data;

endmodule

// File: tb/tb_dwdata_recv.sv
// Bench for dwdata_recv: random R-beat stimulus against a burst/beat-count model,
// with a second instance at BUF_DEPTH=32 to observe address wrap.
module tb_dwdata_recv;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [7:0]  i_num_bursts;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_rlast;
    logic [1:0]  i_rresp;

    logic        o_busy, o_done, o_err, o_weight_load, o_init_addr_en, o_rready, o_buf_wr_en;
    logic [7:0]  o_buf_wr_addr;
    logic [31:0] o_buf_wr_data;

    logic        b_busy, b_done, b_err, b_weight_load, b_init_addr_en, b_rready, b_buf_wr_en;
    logic [4:0]  b_buf_wr_addr;
    logic [31:0] b_buf_wr_data;

    always #5 clk = ~clk;

    dwdata_recv #(.DW(32), .BURST(16), .BUF_DEPTH(256)) u_dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_num_bursts(i_num_bursts),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_weight_load(o_weight_load),
        .o_init_addr_en(o_init_addr_en), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .i_rlast(i_rlast), .i_rresp(i_rresp), .o_rready(o_rready),
        .o_buf_wr_en(o_buf_wr_en), .o_buf_wr_addr(o_buf_wr_addr), .o_buf_wr_data(o_buf_wr_data)
    );

    dwdata_recv #(.DW(32), .BURST(16), .BUF_DEPTH(32)) u_dut32 (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_num_bursts(i_num_bursts),
        .o_busy(b_busy), .o_done(b_done), .o_err(b_err), .o_weight_load(b_weight_load),
        .o_init_addr_en(b_init_addr_en), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .i_rlast(i_rlast), .i_rresp(i_rresp), .o_rready(b_rready),
        .o_buf_wr_en(b_buf_wr_en), .o_buf_wr_addr(b_buf_wr_addr), .o_buf_wr_data(b_buf_wr_data)
    );

    typedef enum {M_IDLE, M_REQ, M_DATA, M_FIN} mph_t;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_err  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  {63'd0, o_busy}, 64'd0);
        check({tag, "_done"},  {63'd0, o_done}, 64'd0);
        check({tag, "_err"},   {63'd0, o_err}, 64'd0);
        check({tag, "_wl"},    {63'd0, o_weight_load}, 64'd0);
        check({tag, "_init"},  {63'd0, o_init_addr_en}, 64'd0);
        check({tag, "_rready"}, {63'd0, o_rready}, 64'd0);
        check({tag, "_wren"},  {63'd0, o_buf_wr_en}, 64'd0);
        check({tag, "_waddr"}, {56'd0, o_buf_wr_addr}, 64'd0);
        check({tag, "_wdata"}, {32'd0, o_buf_wr_data}, 64'd0);
        check({tag, "_b_rready"}, {63'd0, b_rready}, 64'd0);
        check({tag, "_b_wren"}, {63'd0, b_buf_wr_en}, 64'd0);
    endtask

    // One complete load; the model tracks phase by counting accepted beats per burst.
    task automatic run_load(input int nb, input int vprob, input bit seq_data,
                            input bit inject, input int rst_beat);
        mph_t        ph, ph_n;
        int          sent = 0, beat = 0, bursts = 0;
        int          nwl = 0, ndone = 0, nwr = 0;
        bit          pend = 1'b0, bad, acc, v, stray = 1'b0, finished = 1'b0, expect_last;
        int          pidx = 0;
        logic [31:0] pdata = '0, data;
        i_start      = 1'b1;
        i_num_bursts = 8'(nb);
        exp_err      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0;
        ph = (nb == 0) ? M_FIN : M_REQ;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("weight_load", {63'd0, o_weight_load}, {63'd0, ph == M_REQ});
            check("init_addr_en", {63'd0, o_init_addr_en}, {63'd0, (ph == M_REQ) && (bursts == 0)});
            check("rready", {63'd0, o_rready}, {63'd0, ph == M_DATA});
            check("busy", {63'd0, o_busy}, {63'd0, ph != M_IDLE});
            check("done", {63'd0, o_done}, {63'd0, ph == M_FIN});
            check("err", {63'd0, o_err}, {63'd0, exp_err});
            check("wr_en", {63'd0, o_buf_wr_en}, {63'd0, pend});
            check("wr_en_d32", {63'd0, b_buf_wr_en}, {63'd0, pend});
            if (pend) begin
                check("wr_addr", {56'd0, o_buf_wr_addr}, 64'(pidx % 256));
                check("wr_data", {32'd0, o_buf_wr_data}, {32'd0, pdata});
                check("wr_addr_d32", {59'd0, b_buf_wr_addr}, 64'(pidx % 32));
            end
            nwl   += int'(o_weight_load);
            ndone += int'(o_done);
            nwr   += int'(o_buf_wr_en);
            if (ph == M_IDLE) begin
                finished = 1'b1;
                break;
            end
            if (rst_beat >= 0 && ph == M_DATA && sent == rst_beat) begin
                i_rst    = 1'b1;
                i_rvalid = 1'b1;
                #1;
                check_all_zero("rst_async");
                repeat (3) begin
                    @(negedge clk);
                    check_all_zero("rst_hold");
                end
                i_rst    = 1'b0;
                i_rvalid = 1'b0;
                @(negedge clk);
                check_all_zero("rst_release");
                $display("load nb=%0d aborted by reset after %0d beats", nb, sent);
                return;
            end
            // A start while busy must be ignored entirely.
            i_start = 1'b0;
            if (ph == M_DATA && !stray) begin
                i_start      = 1'b1;
                i_num_bursts = 8'd5;
                stray        = 1'b1;
            end
            v           = ($urandom_range(99) < vprob);
            data        = seq_data ? 32'(sent) : $urandom;
            expect_last = (beat == 15);
            i_rvalid    = v;
            i_rdata     = data;
            i_rresp     = 2'b00;
            i_rlast     = expect_last;
            if (inject && bursts == 0) begin
                i_rresp = (beat == 5) ? 2'b10 : 2'b00;
                i_rlast = (beat == 10);
            end
            acc  = (ph == M_DATA) && v;
            bad  = acc && ((i_rresp != 2'b00) || (i_rlast != expect_last));
            ph_n = ph;
            case (ph)
                M_REQ:  ph_n = M_DATA;
                M_FIN:  ph_n = M_IDLE;
                M_DATA: begin
                    if (acc) begin
                        beat++;
                        if (beat == 16) begin
                            beat = 0;
                            bursts++;
                            ph_n = (bursts == nb) ? M_FIN : M_REQ;
                        end
                    end
                end
                default: ph_n = ph;
            endcase
            pend = acc;
            if (acc) begin
                pdata = data;
                pidx  = sent;
                sent++;
            end
            ph = ph_n;
            @(posedge clk);
            exp_err = exp_err | bad;
            @(negedge clk);
        end
        i_start  = 1'b0;
        i_rvalid = 1'b0;
        if (!finished) check("timeout", 64'd1, 64'd0);
        check("wl_count", 64'(nwl), 64'(nb));
        check("write_count", 64'(nwr), 64'(nb * 16));
        check("done_count", 64'(ndone), 64'd1);
        $display("load nb=%0d writes=%0d weight_loads=%0d done=%0d err=%0b", nb, nwr, nwl, ndone, o_err);
    endtask

    initial begin
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_num_bursts = 8'd0;
        i_rdata      = '0;
        i_rvalid     = 1'b0;
        i_rlast      = 1'b0;
        i_rresp      = 2'b00;
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);

        run_load(1, 100, 1'b1, 1'b0, -1);   // single burst, data 0..15
        run_load(3, 50, 1'b0, 1'b0, -1);    // gappy rvalid, wrap in 32-deep instance
        run_load(0, 100, 1'b0, 1'b0, -1);   // empty load
        run_load(1, 70, 1'b0, 1'b1, -1);    // rresp/rlast errors
        repeat (3) begin
            @(negedge clk);
            check("err_sticky", {63'd0, o_err}, 64'd1);
        end
        run_load(2, 80, 1'b0, 1'b0, -1);    // new start clears err
        run_load(3, 60, 1'b0, 1'b0, 23);    // reset on beat 7 of burst 2
        run_load(1, 100, 1'b1, 1'b0, -1);   // clean restart after abort
        run_load(4, 40, 1'b0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
